// File: rtl/rx_dma_req_arbiter.sv
// Round-robin arbiter sharing one DMA engine request port among FLOWS requesters.
// Completions are routed back to the originating flow through an in-order pending-ID FIFO.
module rx_dma_req_arbiter #(
    parameter int FLOWS       = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 1,
    parameter int MAX_PENDING = 4
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [FLOWS-1:0]                   IN_DMA_REQ,
    input  logic [FLOWS*DATA_WIDTH-1:0]        IN_DMA_DOUT,
    output logic [FLOWS*ADDR_WIDTH-1:0]        IN_DMA_ADDR,
    output logic [FLOWS-1:0]                   IN_DMA_ACK,
    output logic [FLOWS-1:0]                   IN_DMA_DONE,
    output logic [FLOWS*16-1:0]                IN_DMA_TAG,
    output logic                               OUT_DMA_REQ,
    output logic [DATA_WIDTH-1:0]              OUT_DMA_DOUT,
    input  logic [ADDR_WIDTH-1:0]              OUT_DMA_ADDR,
    input  logic                               OUT_DMA_ACK,
    input  logic                               OUT_DMA_DONE,
    input  logic [15:0]                        OUT_DMA_TAG,
    output logic [$clog2(MAX_PENDING):0]       PENDING,
    output logic                               DONE_ERR,
    output logic                               dbg_state,
    output logic [$clog2(FLOWS)-1:0]           dbg_rr_ptr
);

    localparam int IDX_W = $clog2(FLOWS);
    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING) + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   cand;
    logic               found;

    logic [IDX_W-1:0]   fifo_mem [MAX_PENDING];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [IDX_W-1:0]   head;
    logic               push, pop;

    logic [FLOWS-1:0]    done_q;
    logic [FLOWS*16-1:0] tag_q;
    logic                err_q;

    // Handshake: a flow holds IN_DMA_REQ until it sees its IN_DMA_ACK bit; the
    // engine sees OUT_DMA_REQ held for the whole grant and accepts with OUT_DMA_ACK.
    assign push = (state_q == S_GRANT) && OUT_DMA_ACK;
    assign pop  = OUT_DMA_DONE && (count_q != '0);
    assign head = fifo_mem[rd_ptr_q];

    // Round-robin search starting at rr_q; FLOWS is a power of two so the add wraps.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < FLOWS; i++) begin
            cand = rr_q + IDX_W'(i);
            if (!found && IN_DMA_REQ[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (found && (count_q < CNT_W'(MAX_PENDING))) begin
                    state_d = S_GRANT;
                    grant_d = sel;
                end
            end
            S_GRANT: begin
                if (OUT_DMA_ACK) begin
                    state_d = S_IDLE;
                    rr_d    = grant_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    // Pending-ID FIFO; a simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= grant_q;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_PENDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_PENDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            done_q <= '0;
            tag_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            done_q <= '0;
            if (pop) begin
                done_q[head]                <= 1'b1;
                tag_q[int'(head)*16 +: 16]  <= OUT_DMA_TAG;
            end
            if (OUT_DMA_DONE && (count_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        IN_DMA_ACK = '0;
        if (push) begin
            IN_DMA_ACK[grant_q] = 1'b1;
        end
    end

    assign OUT_DMA_REQ  = (state_q == S_GRANT);
    assign OUT_DMA_DOUT = (state_q == S_GRANT) ? IN_DMA_DOUT[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH]
                                               : '0;
    assign IN_DMA_ADDR  = {FLOWS{OUT_DMA_ADDR}};
    assign IN_DMA_DONE  = done_q;
    assign IN_DMA_TAG   = tag_q;
    assign PENDING      = count_q;
    assign DONE_ERR     = err_q;
    assign dbg_state    = (state_q == S_GRANT);
    assign dbg_rr_ptr   = rr_q;

endmodule
